// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared 8-bit ALU: grants one requester,
// drives its operands for a single execute cycle, then returns the registered result.
module alu_arbiter #(
  parameter int W    = 8,
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req0_valid_i,
  input  logic            req1_valid_i,
  output logic            req0_ready_o,
  output logic            req1_ready_o,
  input  logic [W-1:0]    req0_a_i,
  input  logic [W-1:0]    req0_b_i,
  input  logic [W-1:0]    req1_a_i,
  input  logic [W-1:0]    req1_b_i,
  input  logic [OPW-1:0]  req0_op_i,
  input  logic [OPW-1:0]  req1_op_i,
  output logic            rsp0_valid_o,
  output logic            rsp1_valid_o,
  input  logic            rsp0_ready_i,
  input  logic            rsp1_ready_i,
  output logic [W-1:0]    rsp_data_o,
  output logic [W-1:0]    alu_a_o,
  output logic [W-1:0]    alu_b_o,
  output logic [OPW-1:0]  alu_op_o,
  input  logic [W-1:0]    alu_res_i,
  output logic            busy_o,
  output logic [CNTW-1:0] op_count_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            own_q, own_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      vld, gnt, rdy, rsp_rdy;

  assign vld     = {req1_valid_i, req0_valid_i};
  assign rsp_rdy = {rsp1_ready_i, rsp0_ready_i};

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = vld;
    if (vld == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // Gated by reset so no handshake is offered while the block is held in reset.
  assign rdy = (state_q == IDLE && rst_ni) ? gnt : 2'b00;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|rdy) begin
          own_d   = rdy[1];
          last_d  = rdy[1];
          a_d     = rdy[1] ? req1_a_i  : req0_a_i;
          b_d     = rdy[1] ? req1_b_i  : req0_b_i;
          op_d    = rdy[1] ? req1_op_i : req0_op_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res_i;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_rdy[own_q]) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready_o = rdy[0];
  assign req1_ready_o = rdy[1];
  assign rsp0_valid_o = (state_q == RESP) && !own_q;
  assign rsp1_valid_o = (state_q == RESP) &&  own_q;
  assign busy_o       = (state_q != IDLE);
  assign rsp_data_o   = res_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_op_o     = op_q;
  assign op_count_o   = cnt_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared combinational 8-bit ALU. Arbitrates round-robin between two requester ports, latches the winning operands and opcode, drives them to the ALU for one execute cycle, and registers the result. It then returns the result to the winning requester over a valid/ready response channel. It sits between the instruction-issue logic and the ALU instance, so the ALU is never driven by more than one source.

## Interface
- W, 8, operand/result width (matches ALU)
- OPW, 3, opcode width (matches ALU)
- CNTW, 16, width of completed-operation counter
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req0_valid_i / req1_valid_i  in  1  requester has an operation pending
- req0_ready_o / req1_ready_o  out  1  operation accepted this cycle when valid&ready
- req0_a_i, req0_b_i / req1_a_i, req1_b_i  in  W  operands
- req0_op_i / req1_op_i  in  OPW  opcode, passed to ALU unmodified
- rsp0_valid_o / rsp1_valid_o  out  1  result available for that requester
- rsp0_ready_i / rsp1_ready_i  in  1  requester consumes result when valid&ready
- rsp_data_o  out  W  registered result, shared by both response ports
- alu_a_o, alu_b_o  out  W  operands to ALU
- alu_op_o  out  OPW  opcode to ALU
- alu_res_i  in  W  ALU combinational result
- busy_o  out  1  high in EXEC or RESP
- op_count_o  out  CNTW  number of completed responses, wraps modulo 2^CNTW

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant is combinational from the two valid inputs and the `last_grant` register.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than `last_grant` is granted.
  - Neither valid: no grant.
  - `reqN_ready_o` = (state == IDLE) && (grant == N). Never both high. Always low outside IDLE.
  - On handshake: latch a, b and op into the `alu_*_o` registers, latch the owner ID, set `last_grant` to the owner, and go to EXEC.
- EXEC, exactly one cycle: `alu_*_o` are stable. At the clock edge, `alu_res_i` is captured into `rsp_data_o`. Go to RESP.
- RESP:
  - `rsp<owner>_valid_o` = 1; the other response valid is 0.
  - `rsp_data_o` is held stable.
  - On `rsp<owner>_ready_i` = 1: increment `op_count_o` and return to IDLE.
  - A ready from the non-owner is ignored.
- `alu_*_o` hold their last latched values outside EXEC; they are never cleared except by reset.
- Counter wraps from 2^CNTW-1 to 0 with no flag.
- Reset values:
  - All `*_ready_o`, `rsp*_valid_o` and `busy_o` = 0.
  - `rsp_data_o`, `alu_a_o`, `alu_b_o`, `alu_op_o` and `op_count_o` = 0.
  - `last_grant` = 1, so requester 0 wins the first contention.
- Reset asserted mid-operation, in EXEC or RESP: the operation is discarded, no response is issued, the counter is not incremented, and the FSM returns to IDLE asynchronously.
- Request inputs are not sampled outside IDLE. Requesters must hold valid and data stable until ready.

## Timing
- Handshake at edge N → EXEC during cycle N+1 → `rsp_valid` high from cycle N+2.
- Minimum request-to-response latency is 2 cycles.
- Response consumed at edge M → IDLE in cycle M+1 → the next request can be accepted at edge M+1.
- Peak throughput is one operation per 3 cycles.
- With back-to-back contention, grants strictly alternate 0,1,0,1 as long as both valids stay high.
- A held response stalls the block indefinitely; no timeout.
- All outputs are registered except `reqN_ready_o`, which is combinational from state, valid inputs and `last_grant`.

## Test plan
For all scenarios, the bench ALU model drives `alu_res_i` = (`alu_a_o` + `alu_b_o`) mod 256, regardless of op.

- **Reset values:** hold `rst_ni` = 0 with random inputs → all outputs 0; after release, first contention (both valid) grants requester 0.
- **Single request, latency and counter:** req0 a=8'h7F, b=8'h01, op=3'b010, `rsp0_ready_i` = 1 → `alu_op_o` = 3'b010 in EXEC; `rsp0_valid_o` at handshake+2 with `rsp_data_o` = 8'h80; `rsp1_valid_o` stays 0; `op_count_o` = 1.
- **Contention fairness:** both requesters valid continuously for 6 operations, req0 a=8'h10, b=8'h01 and req1 a=8'hF0, b=8'h20 → owners 0,1,0,1,0,1. Results 8'h11 and 8'h10 (wraps). Ready is never high on both ports in the same cycle.
- **Response backpressure:** `rsp1_ready_i` held 0 for 10 cycles while req0 stays valid → `rsp1_valid_o` and `rsp_data_o` stable; `req0_ready_o` stays 0; `rsp0_ready_i` pulses are ignored; req0 is accepted in the cycle after the rsp1 handshake.
- **Reset mid-operation:** assert `rst_ni` = 0 during RESP → `rsp_valid` drops immediately; `op_count_o` is unchanged at 0 (not incremented for the dropped op); FSM returns to IDLE.
- **Counter wrap:** build with CNTW=2 and run 5 operations → `op_count_o` sequence 1,2,3,0,1.
